// File: rtl/lcd_line_prefetch.sv
// Ping-pong line buffer between the frame store and the LVDS output stage.
// Optional feature: LCD_PREFETCH_UNDERRUN_CNT_EN enables the saturating late-fetch counter.
module lcd_line_prefetch #(
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 600,
    parameter int          BURST_LEN = 16,
    parameter logic [19:0] BASE_ADDR = 20'h00000
) (
    input  logic        lvds_parallel_clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  line_idx,
    input  logic        pix_en,
    output logic [23:0] pix_rgb,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [23:0] mem_rdata,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [PW-1:0] PTR_END   = PW'(H_ACTIVE);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [9:0]    LAST_LINE = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_r, nxt_state_s;
    logic [PW-1:0] wr_ptr_r, nxt_wr_s;
    logic [PW-1:0] rd_ptr_r;
    logic [9:0]    tgt_line_r, nxt_tgt_s;
    logic [BW-1:0] beat_cnt_r, nxt_beat_s;
    logic          pending_r, nxt_pend_s;
    logic          trig_s, fetch_s, late_s, last_s, pend_now_s;
    logic          sel_r;
    logic [23:0]   front_s;

    logic [23:0] buf0_r [H_ACTIVE];
    logic [23:0] buf1_r [H_ACTIVE];

    // Address is formed at full width, then wraps to the 20-bit bus.
    function automatic logic [19:0] burst_addr(input logic [9:0] line, input logic [PW-1:0] ptr);
        logic [31:0] full;
        full = {12'd0, BASE_ADDR} + 32'(line) * 32'(H_ACTIVE) + 32'(ptr);
        return full[19:0];
    endfunction

    // Trigger decode and next-state/pointer computation.
    always_comb begin
        nxt_state_s = state_r;
        nxt_wr_s    = wr_ptr_r;
        nxt_tgt_s   = tgt_line_r;
        nxt_beat_s  = beat_cnt_r;
        nxt_pend_s  = pending_r;
        trig_s      = 1'b0;
        fetch_s     = 1'b0;
        late_s      = 1'b0;
        last_s      = mem_rvalid && (beat_cnt_r == BEAT_LAST);
        if (line_start) begin
            trig_s   = 1'b1;
            nxt_wr_s = '0;
            late_s   = (state_r != IDLE);
            if (line_idx < LAST_LINE) begin
                fetch_s   = 1'b1;
                nxt_tgt_s = line_idx + 10'd1;
            end else begin
                fetch_s = 1'b0;
            end
        end else if (frame_start) begin
            trig_s    = 1'b1;
            fetch_s   = 1'b1;
            nxt_wr_s  = '0;
            nxt_tgt_s = 10'd0;
        end else begin
            trig_s = 1'b0;
        end
        if (trig_s) begin
            pend_now_s = fetch_s;
        end else begin
            pend_now_s = pending_r;
        end
        case (state_r)
            IDLE: begin
                if (trig_s && fetch_s) nxt_state_s = REQ;
                else                   nxt_state_s = IDLE;
            end
            REQ: begin
                // A grant coinciding with an abort still delivers a whole burst to discard.
                if (mem_gnt) begin
                    nxt_beat_s  = '0;
                    nxt_pend_s  = pend_now_s;
                    nxt_state_s = trig_s ? DRAIN : BURST;
                end else if (trig_s) begin
                    nxt_state_s = fetch_s ? REQ : IDLE;
                end else begin
                    nxt_state_s = REQ;
                end
            end
            BURST: begin
                if (mem_rvalid) nxt_beat_s = beat_cnt_r + BEAT_ONE;
                else            nxt_beat_s = beat_cnt_r;
                if (trig_s) begin
                    nxt_pend_s  = fetch_s;
                    nxt_state_s = last_s ? (fetch_s ? REQ : IDLE) : DRAIN;
                end else begin
                    if (mem_rvalid) nxt_wr_s = wr_ptr_r + PTR_ONE;
                    else            nxt_wr_s = wr_ptr_r;
                    if (last_s) nxt_state_s = ((wr_ptr_r + PTR_ONE) < PTR_END) ? REQ : IDLE;
                    else        nxt_state_s = BURST;
                end
            end
            DRAIN: begin
                nxt_pend_s = pend_now_s;
                if (mem_rvalid) nxt_beat_s = beat_cnt_r + BEAT_ONE;
                else            nxt_beat_s = beat_cnt_r;
                if (last_s) nxt_state_s = pend_now_s ? REQ : IDLE;
                else        nxt_state_s = DRAIN;
            end
            default: nxt_state_s = IDLE;
        endcase
    end

    // Fetch FSM state and its registered memory-side outputs.
    always_ff @(posedge lvds_parallel_clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            tgt_line_r <= 10'd0;
            beat_cnt_r <= '0;
            pending_r  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 20'h00000;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            wr_ptr_r   <= nxt_wr_s;
            tgt_line_r <= nxt_tgt_s;
            beat_cnt_r <= nxt_beat_s;
            pending_r  <= nxt_pend_s;
            mem_req    <= (nxt_state_s == REQ);
            busy       <= (nxt_state_s != IDLE);
            underrun   <= underrun | late_s;
            if (nxt_state_s == REQ) mem_addr <= burst_addr(nxt_tgt_s, nxt_wr_s);
            else                    mem_addr <= mem_addr;
        end
    end

    // Back-buffer write; sel=0 means buf1 is the back buffer.
    always_ff @(posedge lvds_parallel_clk) begin
        if ((state_r == BURST) && mem_rvalid) begin
            if (sel_r) buf0_r[wr_ptr_r[AW-1:0]] <= mem_rdata;
            else       buf1_r[wr_ptr_r[AW-1:0]] <= mem_rdata;
        end
    end

    // Front-buffer read port.
    always_comb begin
        if (sel_r) front_s = buf1_r[rd_ptr_r[AW-1:0]];
        else       front_s = buf0_r[rd_ptr_r[AW-1:0]];
    end

    // Pixel delivery, buffer swap and saturating read pointer.
    always_ff @(posedge lvds_parallel_clk) begin
        if (!rst_n) begin
            sel_r    <= 1'b0;
            rd_ptr_r <= '0;
            pix_rgb  <= 24'h000000;
        end else begin
            if (line_start) sel_r <= ~sel_r;
            else            sel_r <= sel_r;
            if (line_start)                          rd_ptr_r <= '0;
            else if (pix_en && (rd_ptr_r != PTR_END)) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            else                                     rd_ptr_r <= rd_ptr_r;
            if (pix_en && (rd_ptr_r != PTR_END)) pix_rgb <= front_s;
            else                                 pix_rgb <= 24'h000000;
        end
    end

`ifdef LCD_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt_r;

    // Saturating count of late-fetch events.
    always_ff @(posedge lvds_parallel_clk) begin
        if (!rst_n)                          ucnt_r <= 16'h0000;
        else if (late_s && (ucnt_r != 16'hFFFF)) ucnt_r <= ucnt_r + 16'h0001;
        else                                 ucnt_r <= ucnt_r;
    end

    assign underrun_cnt = ucnt_r;
`else
    assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_line_prefetch.sv
// Directed self-checking bench for lcd_line_prefetch (default parameters).
module tb_lcd_line_prefetch;

    localparam int H  = 1024;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_idx = 10'd0;
    logic        pix_en = 1'b0;
    logic [23:0] pix_rgb;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [23:0] mem_rdata = 24'h000000;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LCD_PREFETCH_UNDERRUN_CNT_EN
    localparam logic [15:0] UCNT_AFTER_LATE = 16'd1;
`else
    localparam logic [15:0] UCNT_AFTER_LATE = 16'd0;
`endif

    lcd_line_prefetch dut (
        .lvds_parallel_clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .line_start(line_start),
        .line_idx(line_idx),
        .pix_en(pix_en),
        .pix_rgb(pix_rgb),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] data_of(input logic [9:0] line, input int w);
        logic [9:0] wl;
        wl = w[9:0];
        return {4'hA, line, wl};
    endfunction

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        check_eq("mem_req_wait", {31'd0, mem_req}, 32'd1);
    endtask

    // Serve all bursts of one line: immediate grant, back-to-back beats.
    task automatic serve_line(input logic [9:0] line);
        for (int b = 0; b < H / BL; b++) begin
            wait_req();
            check_eq("mem_addr", {12'd0, mem_addr}, 32'(line) * 32'(H) + 32'(b * BL));
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            check_eq("req_drop", {31'd0, mem_req}, 32'd0);
            for (int k = 0; k < BL; k++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(line, b * BL + k);
                if (b == H / BL - 1 && k == BL - 1) check_eq("busy_last_beat", {31'd0, busy}, 32'd1);
                tick();
            end
            mem_rvalid = 1'b0;
        end
        check_eq("busy_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_line(input logic [9:0] line, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pix_en = 1'b1;
            tick();
            if (i < H) check_eq("pix_rgb", {8'd0, pix_rgb}, {8'd0, data_of(line, i)});
            else       check_eq("pix_tail", {8'd0, pix_rgb}, 32'd0);
        end
        pix_en = 1'b0;
        tick();
        check_eq("pix_idle", {8'd0, pix_rgb}, 32'd0);
    endtask

    task automatic pulse_line(input logic [9:0] idx);
        line_start = 1'b1;
        line_idx   = idx;
        tick();
        line_start = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check_eq("rst_pix", {8'd0, pix_rgb}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_addr", {12'd0, mem_addr}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("rst_ucnt", {16'd0, underrun_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_req", {31'd0, mem_req}, 32'd0);

        // Frame start prefetches line 0
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("fs_req", {31'd0, mem_req}, 32'd1);
        check_eq("fs_busy", {31'd0, busy}, 32'd1);
        serve_line(10'd0);

        // Display line 0 while line 1 is fetched
        pulse_line(10'd0);
        fork
            serve_line(10'd1);
            read_line(10'd0, H);
        join
        check_eq("no_underrun", {31'd0, underrun}, 32'd0);

        // Last line: no fetch
        pulse_line(10'd599);
        for (int i = 0; i < 4; i++) begin
            check_eq("last_req", {31'd0, mem_req}, 32'd0);
            check_eq("last_busy", {31'd0, busy}, 32'd0);
            tick();
        end

        // Late fetch: abort with 5 beats outstanding
        pulse_line(10'd5);
        wait_req();
        check_eq("late_addr", {12'd0, mem_addr}, 32'd6144);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int k = 0; k < 11; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data_of(10'd6, k);
            tick();
        end
        mem_rvalid = 1'b0;
        pulse_line(10'd9);
        check_eq("underrun_set", {31'd0, underrun}, 32'd1);
        check_eq("drain_busy", {31'd0, busy}, 32'd1);
        check_eq("drain_req0", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 24'hDEAD00;
            tick();
            check_eq("drain_req", {31'd0, mem_req}, (k == 4) ? 32'd1 : 32'd0);
        end
        mem_rvalid = 1'b0;
        check_eq("restart_addr", {12'd0, mem_addr}, 32'd10240);
        check_eq("ucnt_late", {16'd0, underrun_cnt}, {16'd0, UCNT_AFTER_LATE});
        serve_line(10'd10);

        // Overlong read saturates; line 11 fetch left pending in REQ
        pulse_line(10'd10);
        read_line(10'd10, H + 6);
        check_eq("rd_ptr_sat", {21'd0, dut.rd_ptr_r}, 32'd1024);
        check_eq("pend_req", {31'd0, mem_req}, 32'd1);
        check_eq("pend_addr", {12'd0, mem_addr}, 32'd11264);

        // Frame start while busy retargets without a new underrun event
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("fs_abort_req", {31'd0, mem_req}, 32'd1);
        check_eq("fs_abort_addr", {12'd0, mem_addr}, 32'd0);
        check_eq("fs_abort_ucnt", {16'd0, underrun_cnt}, {16'd0, UCNT_AFTER_LATE});
        check_eq("underrun_sticky", {31'd0, underrun}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
